// File: rtl/wmem_hidden_seq.sv
// Read sequencer and write arbiter for the hidden-layer weight BRAM.
// Streams all weights in address order through a 2-entry skid FIFO that absorbs the 1-cycle BRAM latency.
module wmem_hidden_seq #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_IN     = 128,
    parameter int unsigned N_HIDDEN = 64,
    localparam int unsigned WSIZE   = N_HIDDEN * N_IN,
    localparam int unsigned AW      = $clog2((WSIZE > 2) ? WSIZE : 2),
    localparam int unsigned NW      = $clog2((N_HIDDEN > 2) ? N_HIDDEN : 2),
    localparam int unsigned IW      = $clog2((N_IN > 2) ? N_IN : 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              host_wr_req,
    output logic              host_wr_gnt,
    output logic              mem_wr_en,
    output logic [AW-1:0]     mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [NW-1:0]     w_neuron,
    output logic              w_first,
    output logic              w_last
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [AW-1:0]     cnt;
    logic [IW-1:0]     i_cnt;
    logic [NW-1:0]     n_cnt;
    logic [AW-1:0]     raddr_q;
    logic              inflight;
    logic [NW-1:0]     tag_neuron;
    logic              tag_first;
    logic              tag_last;
    logic              issue;
    logic              flush;
    logic              pop;
    logic              push;
    logic [2:0]        level;

    logic [DATA_W-1:0] data_mem   [2];
    logic [NW-1:0]     neuron_mem [2];
    logic              first_mem  [2];
    logic              last_mem   [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    assign pop   = w_valid & w_ready;
    assign push  = inflight;
    // Occupancy the FIFO will have once this cycle's pop and the returning read settle.
    assign level = 3'(count) + 3'(inflight) - 3'(pop);
    assign flush = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  if (start && !abort) state_nxt = ARM;
            ARM:   state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (level < 3'd2) begin
                    issue = 1'b1;
                    if (cnt == AW'(WSIZE - 1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort)                             state_nxt = IDLE;
                else if (!inflight && level == 3'd0)   state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/tag counters and the single-stage read-return tracker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            i_cnt      <= '0;
            n_cnt      <= '0;
            raddr_q    <= '0;
            inflight   <= 1'b0;
            tag_neuron <= '0;
            tag_first  <= 1'b0;
            tag_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= (state_nxt == DONE);
            inflight <= issue;
            if (state == IDLE) begin
                cnt   <= '0;
                i_cnt <= '0;
                n_cnt <= '0;
            end else if (issue) begin
                cnt        <= cnt + AW'(1);
                raddr_q    <= cnt;
                tag_neuron <= n_cnt;
                tag_first  <= (i_cnt == '0);
                tag_last   <= (i_cnt == IW'(N_IN - 1));
                if (i_cnt == IW'(N_IN - 1)) begin
                    i_cnt <= '0;
                    n_cnt <= n_cnt + NW'(1);
                end else begin
                    i_cnt <= i_cnt + IW'(1);
                end
            end
        end
    end

    // 2-entry skid FIFO; abort drops both stored words and the returning read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
            for (int k = 0; k < 2; k++) begin
                data_mem[k]   <= '0;
                neuron_mem[k] <= '0;
                first_mem[k]  <= 1'b0;
                last_mem[k]   <= 1'b0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr]   <= mem_rdata;
                neuron_mem[wr_ptr] <= tag_neuron;
                first_mem[wr_ptr]  <= tag_first;
                last_mem[wr_ptr]   <= tag_last;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign busy        = (state != IDLE);
    assign host_wr_gnt = host_wr_req && (state == IDLE) && !start;
    assign mem_wr_en   = host_wr_gnt;
    assign mem_raddr   = issue ? cnt : raddr_q;
    assign w_valid     = (count != 2'd0);
    assign w_data      = data_mem[rd_ptr];
    assign w_neuron    = neuron_mem[rd_ptr];
    assign w_first     = first_mem[rd_ptr];
    assign w_last      = last_mem[rd_ptr];

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && count == 2'd2) |-> pop);
    a_raddr_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(mem_raddr) < WSIZE);
    a_bp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (w_valid && !w_ready && !flush) |=> ($stable(w_data) && $stable(w_neuron)
                                             && $stable(w_first) && $stable(w_last)));
`endif

endmodule
